// File: rtl/e1_tx_hdb3_enc.sv
// E1 transmit HDB3/AMI line encoder.
// Takes the framed serial bit stream one strobe per E1 bit. Each bit is held
// in a four-symbol pipe before it is emitted as a ternary pulse, so a run of
// four zeros can be replaced by 000V or B00V.
module e1_tx_hdb3_enc #(
    parameter logic POL_INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in_bit,
    input  logic in_valid,
    input  logic ctrl_hdb3,
    output logic out_pos,
    output logic out_neg,
    output logic out_valid
);

    typedef enum logic [1:0] {
        SYM_ZERO = 2'd0,
        SYM_ONE  = 2'd1,
        SYM_B    = 2'd2,
        SYM_V    = 2'd3
    } sym_e;

    // s0 holds the newest symbol and s3 holds the oldest.
    sym_e s0, s1, s2, s3;
    // last_pol = 1 means the most recent mark was positive.
    logic last_pol;
    // parity counts marks (mod 2) since the last violation.
    logic parity;

    logic mark_pos_c;
    logic mark_neg_c;
    logic pol_nxt_c;
    logic par_nxt_c;
    logic sub_c;
    logic use_b_c;

    // Emission of s3, polarity/parity update, and zero-run substitution decision.
    always_comb begin
        mark_pos_c = 1'b0;
        mark_neg_c = 1'b0;
        pol_nxt_c  = last_pol;
        par_nxt_c  = parity;
        case (s3)
            SYM_ONE, SYM_B: begin
                // A mark or B pulse alternates relative to the previous mark.
                mark_pos_c = ~last_pol;
                mark_neg_c = last_pol;
                pol_nxt_c  = ~last_pol;
                par_nxt_c  = ~parity;
            end
            SYM_V: begin
                // A violation repeats the previous polarity and restarts parity.
                mark_pos_c = last_pol;
                mark_neg_c = ~last_pol;
                par_nxt_c  = 1'b0;
            end
            default: begin
            end
        endcase
        // The incoming zero completes four zeros. The parity used is the
        // value after this strobe's emission.
        sub_c   = ctrl_hdb3 & ~in_bit &
                  (s2 == SYM_ZERO) & (s1 == SYM_ZERO) & (s0 == SYM_ZERO);
        use_b_c = sub_c & ~par_nxt_c;
    end

    // The symbol pipe, polarity state and registered line outputs advance on each strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0        <= SYM_ZERO;
            s1        <= SYM_ZERO;
            s2        <= SYM_ZERO;
            s3        <= SYM_ZERO;
            last_pol  <= POL_INIT;
            parity    <= 1'b0;
            out_pos   <= 1'b0;
            out_neg   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_pos  <= mark_pos_c;
                out_neg  <= mark_neg_c;
                last_pol <= pol_nxt_c;
                parity   <= par_nxt_c;
                s3       <= use_b_c ? SYM_B : s2;
                s2       <= s1;
                s1       <= s0;
                if (sub_c) begin
                    s0 <= SYM_V;
                end else if (in_bit) begin
                    s0 <= SYM_ONE;
                end else begin
                    s0 <= SYM_ZERO;
                end
            end
        end
    end

endmodule
